// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with tick prescaler, load/clear,
// wrap or saturate at terminal value, and active-low 7-seg per digit.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   en       - count enable; prescaler and count freeze when low
//   up_dn    - 1 = count up, 0 = count down
//   wrap     - 1 = wrap at terminal value, 0 = saturate
//   clear    - synchronous clear (highest priority)
//   load     - synchronous parallel load of load_val (clamped)
//   load_val - packed BCD load value, digit i in [4i+3:4i]
//   bcd      - registered packed BCD count
//   seg      - active-low segments {g,f,e,d,c,b,a}, digit i in [7i+6:7i]
//   tick     - one-cycle pulse per count tick
//   tc       - one-cycle pulse when a tick hits the terminal value
//   done     - saturate mode and count sits at the terminal value
module bcd_counter_n #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_MAX    = 12500000,
  parameter int DIV_W      = 26,
  parameter int MSD_MAX    = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    wrap,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    tick,
  output logic                    tc,
  output logic                    done
);

  localparam int BW = 4*NUM_DIGITS;
  localparam logic [DIV_W-1:0] PMAX = DIV_W'(DIV_MAX-1);
  localparam logic [3:0] MSD_V = 4'(MSD_MAX);

  function automatic logic [3:0] dmax(input int i);
    return (i == NUM_DIGITS-1) ? MSD_V : 4'd9;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b1111111;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0] presc;
  logic             tick_cyc;
  logic             at_term;
  logic [BW-1:0]    term_up;
  logic [BW-1:0]    bcd_nxt;
  logic [BW-1:0]    bcd_upd;
  logic [BW-1:0]    bcd_ld;
  logic             carry;
  logic [3:0]       dig;

  assign tick_cyc = en && (presc == PMAX);

  always_comb begin
    term_up = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      term_up[4*i +: 4] = dmax(i);
  end

  assign at_term = up_dn ? (bcd == term_up)
                         : (bcd == '0);
  assign done = !wrap && at_term;

  // Carry/borrow ripples through all digits in one cycle; at the
  // terminal value this naturally yields the wrapped value.
  always_comb begin
    carry   = 1'b1;
    dig     = 4'd0;
    bcd_nxt = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig = bcd[4*i +: 4];
      if (carry) begin
        if (up_dn) begin
          if (dig >= dmax(i)) dig = 4'd0;
          else begin
            dig   = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) dig = dmax(i);
          else begin
            dig   = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
      bcd_nxt[4*i +: 4] = dig;
    end
  end

  assign bcd_upd = (at_term && !wrap) ? bcd : bcd_nxt;

  always_comb begin
    bcd_ld = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      bcd_ld[4*i +: 4] = (load_val[4*i +: 4] > dmax(i))
                       ? dmax(i) : load_val[4*i +: 4];
  end

  always_comb begin
    seg = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      seg[7*i +: 7] = seg7(bcd[4*i +: 4]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      bcd   <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (clear) begin
      presc <= '0;
      bcd   <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (load) begin
      presc <= '0;
      bcd   <= bcd_ld;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (tick_cyc) begin
      presc <= '0;
      bcd   <= bcd_upd;
      tick  <= 1'b1;
      tc    <= at_term;
    end else begin
      if (en) presc <= presc + 1'b1;
      tick <= 1'b0;
      tc   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: scoreboard of per-cycle expectations
// on bcd/tick/tc plus direct checks of done, seg and async reset.
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        up_dn = 1'b0;
  logic        wrap = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  load_val = '0;
  logic [15:0] load_val4 = '0;
  logic [7:0]  bcd;
  logic [13:0] seg;
  logic        tick, tc, done;
  logic [15:0] bcd4;
  logic [27:0] seg4;
  logic        tick4, tc4, done4;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] b;
    logic       t;
    logic       c;
  } exp_t;

  exp_t q[$];

  bcd_counter_n #(
    .NUM_DIGITS(2), .DIV_MAX(4), .DIV_W(3), .MSD_MAX(5)
  ) u_dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn),
    .wrap(wrap), .clear(clear), .load(load),
    .load_val(load_val), .bcd(bcd), .seg(seg),
    .tick(tick), .tc(tc), .done(done)
  );

  bcd_counter_n #(
    .NUM_DIGITS(4), .DIV_MAX(4), .DIV_W(3), .MSD_MAX(9)
  ) u_dut4 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn),
    .wrap(wrap), .clear(clear), .load(load),
    .load_val(load_val4), .bcd(bcd4), .seg(seg4),
    .tick(tick4), .tc(tc4), .done(done4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input int at, input string tag,
                      input logic [7:0] b,
                      input logic t, input logic c);
    exp_t e;
    e.cyc = at;
    e.tag = tag;
    e.b   = b;
    e.t   = t;
    e.c   = c;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc == cyc)
        chk(e.tag, 32'({bcd, tick, tc}),
            32'({e.b, e.t, e.c}));
      else
        chk({e.tag, "_missed"}, 32'(cyc), 32'(e.cyc));
    end
  end

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    wait_cyc(2);
    chk("rst_bcd", 32'(bcd), 32'h00);
    chk("rst_tick", 32'({tick, tc}), 32'h0);
    chk("rst_done", 32'(done), 32'h1);
    chk("rst_seg", 32'(seg), 32'({7'b1000000, 7'b1000000}));

    drv(); c = cyc;
    reset = 1'b1; en = 1'b1; up_dn = 1'b1; wrap = 1'b1;
    push(c+3, "pre_tick", 8'h00, 1'b0, 1'b0);
    push(c+4, "tick1", 8'h01, 1'b1, 1'b0);
    push(c+5, "tick1_end", 8'h01, 1'b0, 1'b0);
    push(c+8, "tick2", 8'h02, 1'b1, 1'b0);
    push(c+12, "tick3", 8'h03, 1'b1, 1'b0);
    wait_cyc(c+4);
    chk("seg_one", 32'(seg[6:0]), 32'(7'b1111001));
    wait_cyc(c+12);

    drv(); c = cyc;
    load = 1'b1; load_val = 8'h58;
    push(c+1, "ld58", 8'h58, 1'b0, 1'b0);
    push(c+5, "up59", 8'h59, 1'b1, 1'b0);
    push(c+9, "upwrap", 8'h00, 1'b1, 1'b1);
    push(c+10, "upwrap_end", 8'h00, 1'b0, 1'b0);
    drv(); load = 1'b0;
    wait_cyc(c+10);

    drv(); c = cyc;
    load = 1'b1; load_val = 8'h7C;
    push(c+1, "clamp", 8'h59, 1'b0, 1'b0);
    drv(); load = 1'b0; en = 1'b0;
    wait_cyc(c+1);

    drv(); c = cyc;
    load = 1'b1; load_val = 8'h01;
    up_dn = 1'b0; wrap = 1'b0; en = 1'b1;
    push(c+1, "ld01", 8'h01, 1'b0, 1'b0);
    push(c+5, "dn00", 8'h00, 1'b1, 1'b0);
    push(c+9, "dnsat", 8'h00, 1'b1, 1'b1);
    push(c+13, "dnwrap", 8'h59, 1'b1, 1'b1);
    drv(); load = 1'b0;
    wait_cyc(c+1);
    chk("done_lo", 32'(done), 32'h0);
    wait_cyc(c+5);
    chk("done_hi", 32'(done), 32'h1);
    wait_cyc(c+9);
    drv(); wrap = 1'b1;
    #1;
    chk("done_wrap", 32'(done), 32'h0);
    wait_cyc(c+13);

    drv(); c = cyc;
    load = 1'b1; load_val = 8'h10; load_val4 = 16'h1000;
    push(c+1, "ld10", 8'h10, 1'b0, 1'b0);
    push(c+5, "borrow", 8'h09, 1'b1, 1'b0);
    drv(); load = 1'b0;
    wait_cyc(c+5);
    chk("borrow4", 32'(bcd4), 32'h0999);
    chk("seg_09", 32'(seg), 32'({7'b1000000, 7'b0010000}));

    wait_cyc(c+6);
    drv();
    en = 1'b0;
    push(c+9, "pause_a", 8'h09, 1'b0, 1'b0);
    push(c+17, "pause_b", 8'h09, 1'b0, 1'b0);
    wait_cyc(c+16);
    drv(); en = 1'b1;
    push(c+18, "resume", 8'h09, 1'b0, 1'b0);
    push(c+19, "resume_tick", 8'h08, 1'b1, 1'b0);
    wait_cyc(c+21);
    drv();
    clear = 1'b1; load = 1'b1; load_val = 8'h33;
    push(c+23, "clr_ld", 8'h00, 1'b0, 1'b0);
    push(c+24, "clr_ld_after", 8'h00, 1'b0, 1'b0);
    drv(); clear = 1'b0; load = 1'b0;
    wait_cyc(c+24);

    drv(); c = cyc;
    load = 1'b1; load_val = 8'h36; up_dn = 1'b1; wrap = 1'b1;
    push(c+1, "ld36", 8'h36, 1'b0, 1'b0);
    push(c+5, "up37", 8'h37, 1'b1, 1'b0);
    drv(); load = 1'b0;
    wait_cyc(c+5);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_bcd", 32'(bcd), 32'h00);
    chk("arst_tick", 32'({tick, tc}), 32'h0);
    chk("arst_seg", 32'(seg), 32'({7'b1000000, 7'b1000000}));
    chk("arst_bcd4", 32'(bcd4), 32'h0000);
    drv(); drv();
    en = 1'b0; reset = 1'b1;
    wait_cyc(cyc + 2);
    chk("sb_drain", 32'(q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
